// File: rtl/systolic_feeder.sv
// Sequencer for a DIM x DIM output-stationary systolic matmul array: clears C,
// feeds skewed A/B k-steps, flushes the wavefront, then streams C out row by row.
module systolic_feeder #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIM*BITS_AB-1:0]    a_vec,
  input  logic [DIM*BITS_AB-1:0]    b_vec,
  output logic [DIM*BITS_AB-1:0]    arr_A,
  output logic [DIM*BITS_AB-1:0]    arr_B,
  output logic                      arr_en,
  output logic                      arr_WrEn,
  output logic [$clog2(DIM)-1:0]    arr_Crow,
  output logic [DIM*BITS_C-1:0]     arr_Cin,
  input  logic [DIM*BITS_C-1:0]     arr_Cout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DIM*BITS_C-1:0]     res_row,
  output logic [$clog2(DIM)-1:0]    res_idx
);

  localparam int CW = $clog2(DIM);
  localparam int NW = $clog2(2 * DIM);
  localparam logic [CW-1:0] LAST_ROW   = CW'(DIM - 1);
  localparam logic [NW-1:0] LAST_K     = NW'(DIM - 1);
  localparam logic [NW-1:0] LAST_FLUSH = NW'(2 * DIM - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                in_ready_q, in_ready_d;
  logic                flush_q, flush_d;
  logic                wr_en_q, wr_en_d;
  logic [CW-1:0]       crow_q, crow_d;
  logic                res_valid_q, res_valid_d;
  logic [DIM*BITS_C-1:0] res_row_q, res_row_d;
  logic [CW-1:0]       res_idx_q, res_idx_d;

  // Both ports use strict valid/ready: a word moves on any clock edge where
  // valid and ready are both high; the sender holds data stable until then.
  logic xfer;
  assign xfer     = in_ready_q & in_valid;
  assign arr_en   = xfer | flush_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign arr_WrEn  = wr_en_q;
  assign arr_Crow  = crow_q;
  assign arr_Cin   = '0;
  assign res_valid = res_valid_q;
  assign res_row   = res_row_q;
  assign res_idx   = res_idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    in_ready_d  = in_ready_q;
    flush_d     = flush_q;
    wr_en_d     = wr_en_q;
    crow_d      = crow_q;
    res_valid_d = res_valid_q;
    res_row_d   = res_row_q;
    res_idx_d   = res_idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          wr_en_d = 1'b1;
          crow_d  = '0;
        end
      end
      S_CLEAR: begin
        if (crow_q == LAST_ROW) begin
          state_d    = S_FEED;
          wr_en_d    = 1'b0;
          crow_d     = '0;
          cnt_d      = '0;
          in_ready_d = 1'b1;
        end else begin
          crow_d = crow_q + 1'b1;
        end
      end
      S_FEED: begin
        if (xfer) begin
          if (cnt_q == LAST_K) begin
            state_d    = S_FLUSH;
            in_ready_d = 1'b0;
            flush_d    = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // The far corner PE sees its last k-step on the final flush cycle.
        if (cnt_q == LAST_FLUSH) begin
          state_d = S_DRAIN;
          flush_d = 1'b0;
          cnt_d   = '0;
          crow_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_row_d   = arr_Cout;
          res_idx_d   = crow_q;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          if (crow_q == LAST_ROW) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            crow_d  = '0;
          end else begin
            crow_d = crow_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      flush_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      crow_q      <= '0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      flush_q     <= flush_d;
      wr_en_q     <= wr_en_d;
      crow_q      <= crow_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // Lane inputs are forced to zero outside transfers so flush pushes zeros.
  logic [BITS_AB-1:0] a_lane [DIM];
  logic [BITS_AB-1:0] b_lane [DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_lane[i] = xfer ? a_vec[i*BITS_AB +: BITS_AB] : '0;
      b_lane[i] = xfer ? b_vec[i*BITS_AB +: BITS_AB] : '0;
    end
  end

  assign arr_A[0 +: BITS_AB] = a_lane[0];
  assign arr_B[0 +: BITS_AB] = b_lane[0];

  for (genvar i = 1; i < DIM; i++) begin : g_lane
    logic [BITS_AB-1:0] a_sr_q [i];
    logic [BITS_AB-1:0] a_sr_d [i];
    logic [BITS_AB-1:0] b_sr_q [i];
    logic [BITS_AB-1:0] b_sr_d [i];

    always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      if (arr_en) begin
        a_sr_d[0] = a_lane[i];
        b_sr_d[0] = b_lane[i];
        for (int d = 1; d < i; d++) begin
          a_sr_d[d] = a_sr_q[d-1];
          b_sr_d[d] = b_sr_q[d-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_sr_q <= '{default: '0};
        b_sr_q <= '{default: '0};
      end else begin
        a_sr_q <= a_sr_d;
        b_sr_q <= b_sr_d;
      end
    end

    assign arr_A[i*BITS_AB +: BITS_AB] = a_sr_q[i-1];
    assign arr_B[i*BITS_AB +: BITS_AB] = b_sr_q[i-1];
  end

endmodule
